// File: rtl/scale_down_param.sv
// scale_down_param
//   Frame downscaler. Loads one IMG_W x IMG_H frame through the ask
//   handshake, then emits the KxK box average of every block in raster
//   order (K=2 when mode=0, K=4 when mode=1; mode is captured on the
//   first LOAD cycle of each frame).
//
//   Optional build macro: SCALE_DOWN_TRUNC_EN
//     defined   -> truncating average (sum >> log2(K*K))
//     undefined -> round-half-up average ((sum + K*K/2) >> log2(K*K))
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in         pixel data, sampled every cycle ask=1
//   mode       0: K=2, 1: K=4
//   out        averaged pixel, valid with display, otherwise 0
//   display    one-cycle strobe per output pixel
//   ask        high while a frame is being loaded
//   frame_done one-cycle pulse with the last display of a frame
module scale_down_param #(
    parameter int DW    = 8,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in,
    input  logic          mode,
    output logic [DW-1:0] out,
    output logic          display,
    output logic          ask,
    output logic          frame_done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int AW = CW + RW;
    localparam int SW = DW + 4;

    typedef enum logic [1:0] {IDLE, LOAD, ACC, OUT} state_t;

    state_t          state, state_nx;
    logic [DW-1:0]   mem [N];
    logic [AW-1:0]   wr_addr;
    logic            mode_q;
    logic [3:0]      idx;
    logic [RW-1:0]   br;
    logic [CW-1:0]   bc;
    logic [SW-1:0]   acc;

    logic [3:0]      last_idx;
    logic [CW-1:0]   last_bc;
    logic [RW-1:0]   last_br;
    logic            block_last;
    logic [RW-1:0]   rd_row;
    logic [CW-1:0]   rd_col;
    logic [DW-1:0]   rd_data;
    logic [SW-1:0]   rounded;
    logic [DW-1:0]   avg;

    assign last_idx   = mode_q ? 4'd15 : 4'd3;
    assign last_bc    = mode_q ? CW'(IMG_W/4 - 1) : CW'(IMG_W/2 - 1);
    assign last_br    = mode_q ? RW'(IMG_H/4 - 1) : RW'(IMG_H/2 - 1);
    assign block_last = (bc == last_bc) && (br == last_br);

    // Row/column of the idx-th pixel inside block (br,bc); idx walks the
    // block row by row, so its upper half selects the row offset.
    always_comb begin
        if (mode_q) begin
            rd_row = (br << 2) | RW'(idx[3:2]);
            rd_col = (bc << 2) | CW'(idx[1:0]);
        end else begin
            rd_row = (br << 1) | RW'(idx[1]);
            rd_col = (bc << 1) | CW'(idx[0]);
        end
    end

    // Power-of-two width makes r*IMG_W + c a plain concatenation.
    assign rd_data = mem[{rd_row, rd_col}];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = LOAD;
            LOAD: if (wr_addr == AW'(N - 1)) state_nx = ACC;
            ACC:  if (idx == last_idx) state_nx = OUT;
            OUT:  state_nx = block_last ? LOAD : ACC;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            wr_addr <= '0;
            mode_q  <= 1'b0;
            idx     <= '0;
            br      <= '0;
            bc      <= '0;
            acc     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                LOAD: begin
                    if (wr_addr == '0) mode_q <= mode;
                    if (wr_addr == AW'(N - 1)) wr_addr <= '0;
                    else                       wr_addr <= wr_addr + 1'b1;
                end
                ACC: begin
                    // First pixel of a block overwrites the previous sum.
                    if (idx == '0) acc <= SW'(rd_data);
                    else           acc <= acc + SW'(rd_data);
                    if (idx == last_idx) idx <= '0;
                    else                 idx <= idx + 1'b1;
                end
                OUT: begin
                    if (bc == last_bc) begin
                        bc <= '0;
                        if (br == last_br) br <= '0;
                        else               br <= br + 1'b1;
                    end else begin
                        bc <= bc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame storage is not reset; writes are suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (!reset && state == LOAD) mem[wr_addr] <= in;
    end

    always_comb begin
`ifdef SCALE_DOWN_TRUNC_EN
        rounded = acc;
`else
        rounded = acc + (mode_q ? SW'(8) : SW'(2));
`endif
        avg = mode_q ? DW'(rounded >> 4) : DW'(rounded >> 2);
    end

    assign ask        = (state == LOAD);
    assign display    = (state == OUT);
    assign out        = display ? avg : '0;
    assign frame_done = display && block_last;

endmodule
